// File: rtl/mmr_bank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: address map, response codes
// and the address decoder used by both the read and the write path.
package mmr_bank_pkg;

    localparam logic [31:0] OFF_RW     = 32'h000;
    localparam logic [31:0] OFF_IRQ    = 32'h100;
    localparam logic [31:0] IRQ_STRIDE = 32'h010;
    localparam logic [31:0] OFF_TSR    = 32'h200;
    localparam logic [31:0] OFF_ERRCNT = 32'h3F0;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [3:0] {
        K_NONE, K_RW, K_ISR, K_IMR, K_IER, K_IDR, K_TSR, K_ERRCNT, K_ERRCLR
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [5:0] index;
        logic       hit;
    } dec_t;

    // hit is set only when the word index exists for the given bank sizes
    function automatic dec_t decode(input logic [31:0] addr, input int n_rw,
                                    input int n_irq, input int n_trig);
        dec_t        d;
        logic [31:0] a;
        a       = {addr[31:2], 2'b00};
        d.kind  = K_NONE;
        d.index = '0;
        d.hit   = 1'b0;
        if (a < OFF_IRQ) begin
            d.kind  = K_RW;
            d.index = a[7:2];
            d.hit   = int'(a[7:2]) < n_rw;
        end else if (a < OFF_TSR) begin
            d.index = {2'b00, a[7:4]};
            d.hit   = int'(a[7:4]) < n_irq;
            case (a[3:2])
                2'd0:    d.kind = K_ISR;
                2'd1:    d.kind = K_IMR;
                2'd2:    d.kind = K_IER;
                default: d.kind = K_IDR;
            endcase
        end else if (a < OFF_TSR + 32'h40) begin
            d.kind  = K_TSR;
            d.index = {2'b00, a[5:2]};
            d.hit   = int'(a[5:2]) < n_trig;
        end else if (a == OFF_ERRCNT) begin
            d.kind = K_ERRCNT;
            d.hit  = 1'b1;
        end else if (a == OFF_ERRCNT + 32'h4) begin
            d.kind = K_ERRCLR;
            d.hit  = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_mmr_bank_if.sv
// AXI4-Lite slave-side bundle for the register bank (32-bit data, byte strobes).
interface axi_lite_mmr_bank_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  awvalid, awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid, wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic                  arvalid, arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid, rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/mmr_irq_word.sv
// One interrupt word: ISR (set pulses, W1C) and IMR (IER sets, IDR clears) with a
// registered interrupt output derived from the current ISR/IMR state.
module mmr_irq_word (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] set_i,
    input  logic [31:0] w1c_i,
    input  logic [31:0] ier_i,
    input  logic [31:0] idr_i,
    output logic [31:0] isr_o,
    output logic [31:0] imr_o,
    output logic        irq_o
);
    logic [31:0] isr_q, isr_d, imr_q, imr_d;
    logic        irq_q;

    // a set pulse wins over a software clear of the same bit
    assign isr_d = (isr_q & ~w1c_i) | set_i;
    assign imr_d = (imr_q | ier_i) & ~idr_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            isr_q <= '0;
            imr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            isr_q <= isr_d;
            imr_q <= imr_d;
            irq_q <= |(isr_q & imr_q);
        end
    end

    assign isr_o = isr_q;
    assign imr_o = imr_q;
    assign irq_o = irq_q;
endmodule

// File: rtl/axi_lite_mmr_bank.sv
// AXI4-Lite register bank: RW control words, ISR/IMR interrupt words, W1S trigger words.
// Optional SLVERR counter at 0x3F0 (clear via bit 31 at 0x3F4) when MMR_ERR_COUNT_EN is defined.
module axi_lite_mmr_bank
    import mmr_bank_pkg::*;
#(
    parameter  int ADDR_WIDTH = 12,
    parameter  int DATA_WIDTH = 32,
    parameter  int N_RW       = 8,
    parameter  int N_IRQ      = 2,
    parameter  int N_TRIG     = 1,
    localparam int IDX_W      = (N_RW > 1) ? $clog2(N_RW) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    axi_lite_mmr_bank_if.slave     s,
    output logic [N_RW*32-1:0]     rw_q,
    input  logic                   hw_store,
    input  logic [IDX_W-1:0]       hw_store_idx,
    input  logic [31:0]            hw_store_data,
    input  logic [N_IRQ*32-1:0]    isr_set,
    input  logic [N_TRIG*32-1:0]   tsr_clr,
    output logic [N_TRIG*32-1:0]   tsr_q,
    output logic [N_IRQ-1:0]       irq_vec,
    output logic                   irq
);
    if (DATA_WIDTH != 32 || N_RW < 1 || N_RW > 64 || N_IRQ < 1 || N_IRQ > 16 ||
        N_TRIG < 1 || N_TRIG > 16) begin : g_bad_cfg
        $error("axi_lite_mmr_bank: unsupported parameter set");
    end

`ifdef MMR_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic logic mapped(input dec_t d);
        return d.hit && (ERR_EN || !(d.kind inside {K_ERRCNT, K_ERRCLR}));
    endfunction

    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d;
    logic                  awready_q, wready_q, arready_q, rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q, wmask, rdata_q, rdata_d, rd_word;
    logic [3:0]            wstrb_q;
    axi_resp_t             bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    dec_t                  wdec, rdec;
    logic [N_RW-1:0][31:0]   rw_reg_q, rw_d;
    logic [N_TRIG-1:0][31:0] tsr_reg_q, tsr_d;
    logic [N_IRQ-1:0][31:0]  isr_w, imr_w;
    logic [15:0]             err_word;

    assign aw_hs  = s.awvalid && awready_q;
    assign w_hs   = s.wvalid && wready_q;
    assign b_hs   = bvalid_q && s.bready;
    assign ar_hs  = s.arvalid && arready_q;
    assign r_hs   = rvalid_q && s.rready;
    assign commit = aw_held_q && w_held_q && !bvalid_q;
    assign wdec   = decode(32'(awaddr_q), N_RW, N_IRQ, N_TRIG);
    assign rdec   = decode(32'(s.araddr), N_RW, N_IRQ, N_TRIG);
    assign wmask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_RW; i++)
            if (rdec.kind == K_RW && rdec.index == 6'(i)) rd_word = rw_reg_q[i];
        for (int k = 0; k < N_IRQ; k++) begin
            if (rdec.kind == K_ISR && rdec.index == 6'(k)) rd_word = isr_w[k];
            if (rdec.kind == K_IMR && rdec.index == 6'(k)) rd_word = imr_w[k];
        end
        for (int k = 0; k < N_TRIG; k++)
            if (rdec.kind == K_TSR && rdec.index == 6'(k)) rd_word = tsr_reg_q[k];
        if (rdec.kind == K_ERRCNT) rd_word = {16'h0, err_word};
        if (!mapped(rdec)) rd_word = '0;
    end

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = mapped(wdec) ? OKAY : SLVERR;
        end
        if (b_hs) bvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = mapped(rdec) ? OKAY : SLVERR;
        end
        if (r_hs) rvalid_d = 1'b0;
    end

    // the AXI write is applied after hw_store so it wins on the same word
    always_comb begin
        rw_d = rw_reg_q;
        for (int i = 0; i < N_RW; i++) begin
            if (hw_store && int'(hw_store_idx) == i) rw_d[i] = hw_store_data;
            if (commit && wdec.kind == K_RW && wdec.index == 6'(i))
                rw_d[i] = (rw_reg_q[i] & ~wmask) | (wdata_q & wmask);
        end
        for (int k = 0; k < N_TRIG; k++) begin
            tsr_d[k] = tsr_reg_q[k] & ~tsr_clr[32*k +: 32];
            if (commit && wdec.kind == K_TSR && wdec.index == 6'(k))
                tsr_d[k] = tsr_d[k] | (wdata_q & wmask);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rw_reg_q  <= '0;
            tsr_reg_q <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            awready_q <= !aw_held_d && !bvalid_d;
            wready_q  <= !w_held_d && !bvalid_d;
            arready_q <= !rvalid_d;
            rw_reg_q  <= rw_d;
            tsr_reg_q <= tsr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (aw_hs) awaddr_q <= s.awaddr;
        if (w_hs) begin
            wdata_q <= s.wdata;
            wstrb_q <= s.wstrb;
        end
    end

    for (genvar k = 0; k < N_IRQ; k++) begin : g_irq
        logic        sel;
        logic [31:0] w1c, ier, idr;
        assign sel = commit && wdec.index == 6'(k);
        assign w1c = (sel && wdec.kind == K_ISR) ? (wdata_q & wmask) : 32'h0;
        assign ier = (sel && wdec.kind == K_IER) ? (wdata_q & wmask) : 32'h0;
        assign idr = (sel && wdec.kind == K_IDR) ? (wdata_q & wmask) : 32'h0;
        mmr_irq_word u_word (
            .clock (clock),
            .reset (reset),
            .set_i (isr_set[32*k +: 32]),
            .w1c_i (w1c),
            .ier_i (ier),
            .idr_i (idr),
            .isr_o (isr_w[k]),
            .imr_o (imr_w[k]),
            .irq_o (irq_vec[k])
        );
    end

`ifdef MMR_ERR_COUNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [1:0]  n_err;
    logic [16:0] err_sum;

    // errors are counted on the edge that raises bvalid/rvalid with SLVERR
    always_comb begin
        n_err     = 2'(commit && !mapped(wdec)) + 2'(ar_hs && !mapped(rdec));
        err_sum   = {1'b0, err_cnt_q} + 17'(n_err);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (commit && wdec.kind == K_ERRCLR && wstrb_q[3] && wdata_q[31]) err_cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_word = err_cnt_q;
`else
    assign err_word = 16'h0;
`endif

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign rw_q      = rw_reg_q;
    assign tsr_q     = tsr_reg_q;
    assign irq       = |irq_vec;
endmodule
